// File: rtl/sprite_ram_loader_if.sv
// Sprite-RAM loader bus bundle: packed-pixel input stream plus the
// registered sprite-RAM write port driven by the loader.
// master: the side that feeds the stream and observes the RAM write port.
// slave : the loader itself.
interface sprite_ram_loader_if #(
    parameter int CD   = 12,
    parameter int ADDR = 10
);
    logic              s_valid;
    logic              s_ready;
    logic [2*CD-1:0]   s_data;
    logic              we;
    logic [ADDR-1:0]   addr_w;
    logic [CD-1:0]     pixel_in;

    modport master (
        output s_valid, s_data,
        input  s_ready, we, addr_w, pixel_in
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, we, addr_w, pixel_in
    );
endinterface

// File: rtl/sprite_ram_loader.sv
// Sprite-RAM loader: unpacks two-pixel stream words into consecutive
// sprite-RAM writes (one pixel per clock) starting at a programmable base.
// Optional macro SPRITE_RAM_LOADER_CSUM_EN adds a 16-bit running checksum
// of all written pixels on output port csum.
module sprite_ram_loader #(
    parameter int CD   = 12,
    parameter int ADDR = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [ADDR-1:0]  start_addr,
    input  logic [ADDR:0]    len,
    sprite_ram_loader_if.slave bus,
    output logic             busy,
`ifdef SPRITE_RAM_LOADER_CSUM_EN
    output logic [15:0]      csum,
`endif
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR-1:0]   ptr_q, ptr_d;
    logic [ADDR:0]     rem_q, rem_d;
    logic [2*CD-1:0]   hold_q, hold_d;
    logic              hold_vld_q, hold_vld_d;
    logic              phase_q, phase_d;
    logic              we_q, we_d;
    logic [ADDR-1:0]   addr_q, addr_d;
    logic [CD-1:0]     pix_q, pix_d;
    logic [15:0]       csum_q, csum_d;

    logic              s_ready_c;
    logic              accept;
    logic              issue;
    logic [CD-1:0]     pix_sel;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            rem_q      <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            phase_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            pix_q      <= '0;
            csum_q     <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            phase_q    <= phase_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            pix_q      <= pix_d;
            csum_q     <= csum_d;
        end
    end

    // Next-state logic: stream acceptance, pixel issue, FSM transitions, abort override.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rem_d      = rem_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        phase_d    = phase_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        pix_d      = pix_q;
        csum_d     = csum_q;

        // Refill is allowed while the high half is being issued so a new word
        // lands in the hold register with no bubble, unless this is the last pixel.
        s_ready_c = (state_q == LOAD) &&
                    (!hold_vld_q || (phase_q && (rem_q > (ADDR+1)'(1))));
        accept    = bus.s_valid && s_ready_c;
        issue     = (state_q == LOAD) && hold_vld_q;
        pix_sel   = phase_q ? hold_q[2*CD-1:CD] : hold_q[CD-1:0];

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ptr_d      = start_addr;
                    rem_d      = len;
                    hold_vld_d = 1'b0;
                    phase_d    = 1'b0;
                    csum_d     = '0;
                    state_d    = (len == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (issue) begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    pix_d   = pix_sel;
                    csum_d  = csum_q + 16'(pix_sel);
                    ptr_d   = ptr_q + 1'b1;
                    rem_d   = rem_q - 1'b1;
                    phase_d = ~phase_q;
                    if (phase_q || (rem_q == (ADDR+1)'(1))) begin
                        hold_vld_d = 1'b0;
                    end
                    if (rem_q == (ADDR+1)'(1)) begin
                        state_d = DONE;
                    end
                end
                if (accept) begin
                    hold_d     = bus.s_data;
                    hold_vld_d = 1'b1;
                    phase_d    = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort discards everything in flight but leaves the last write
        // address/data and the checksum untouched.
        if (abort) begin
            state_d    = IDLE;
            ptr_d      = ptr_q;
            rem_d      = rem_q;
            hold_vld_d = 1'b0;
            phase_d    = 1'b0;
            we_d       = 1'b0;
            addr_d     = addr_q;
            pix_d      = pix_q;
            csum_d     = csum_q;
        end
    end

    assign bus.s_ready  = s_ready_c;
    assign bus.we       = we_q;
    assign bus.addr_w   = addr_q;
    assign bus.pixel_in = pix_q;
    assign busy         = (state_q == LOAD);
    assign done         = (state_q == DONE);

`ifdef SPRITE_RAM_LOADER_CSUM_EN
    assign csum = csum_q;
`else
    logic unused_csum;
    assign unused_csum = ^csum_q;
`endif

endmodule
